madd_dot_sequencer: RTL and testbench

MADD_DOT_SEQUENCER -- requirements
Module: madd_dot_sequencer

---
 rtl/madd_dot_sequencer.sv | 158 +++++++++++++++
 tb/tb_madd_dot_sequencer.sv | 368 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/madd_dot_sequencer.sv
// Feeds 8-lane beats to an external pipelined MADD and accumulates dot products into an output FIFO.
// Optional accumulator overflow detection: define MADD_SEQ_OVF_DETECT_EN.
module madd_dot_sequencer #(
  parameter int MADD_LATENCY = 4,
  parameter int LEN_WIDTH    = 16,
  parameter int OFIFO_DEPTH  = 8
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic [LEN_WIDTH-1:0] cfg_len,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [63:0]          in_a,
  input  logic [63:0]          in_b,
  output logic [63:0]          madd_a,
  output logic [63:0]          madd_b,
  input  logic [31:0]          madd_result,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [31:0]          out_data,
  output logic                 busy,
  output logic                 ovf_flag
);

  localparam int PW = $clog2(OFIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam int OW = CW + 1;
  localparam logic [LEN_WIDTH-1:0] LEN_ONE = LEN_WIDTH'(1);
  localparam logic [OW-1:0] DEPTH_V = OW'(OFIFO_DEPTH);

  typedef enum logic {IDLE, RUN} state_e;

  state_e state_q, state_d;
  logic [LEN_WIDTH-1:0] cnt_q, cnt_d;
  logic [MADD_LATENCY-1:0] tv_q, tv_d;
  logic [MADD_LATENCY-1:0] tf_q, tf_d;
  logic [MADD_LATENCY-1:0] tl_q, tl_d;
  logic [CW-1:0] pend_q, pend_d;
  logic [CW-1:0] count_q, count_d;
  logic [PW-1:0] wr_q, wr_d;
  logic [PW-1:0] rd_q, rd_d;
  logic [31:0] acc_q, acc_d;
  logic [31:0] mem_q [OFIFO_DEPTH];

  logic [LEN_WIDTH-1:0] len_in;
  logic [OW-1:0] occ;
  logic cand_last, fire, is_first;
  logic e_v, e_f, push, pop;
  logic [31:0] acc_sum;

  assign len_in    = (cfg_len == '0) ? LEN_ONE : cfg_len;
  assign cand_last = (state_q == IDLE) ? (len_in == LEN_ONE)
                                       : (cnt_q == LEN_ONE);
  assign occ       = {1'b0, count_q} + {1'b0, pend_q};
  // Only a closing beat needs a reserved FIFO slot, so only it is held back.
  assign in_ready  = ~reset & ~((occ >= DEPTH_V) & cand_last);
  assign fire      = in_valid & in_ready;
  assign is_first  = state_q == IDLE;
  assign madd_a    = fire ? in_a : '0;
  assign madd_b    = fire ? in_b : '0;

  assign e_v     = tv_q[MADD_LATENCY-1];
  assign e_f     = tf_q[MADD_LATENCY-1];
  assign push    = e_v & tl_q[MADD_LATENCY-1];
  assign acc_sum = acc_q + madd_result;

  assign out_valid = count_q != '0;
  assign pop       = out_valid & out_ready;
  assign out_data  = out_valid ? mem_q[rd_q] : '0;
  assign busy      = (state_q == RUN) | (|tv_q);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (fire) begin
      case (state_q)
        IDLE: begin
          cnt_d   = len_in - LEN_ONE;
          state_d = (len_in == LEN_ONE) ? IDLE : RUN;
        end
        RUN: begin
          cnt_d = cnt_q - LEN_ONE;
          if (cnt_q == LEN_ONE) state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_comb begin
    tv_d    = tv_q << 1;
    tf_d    = tf_q << 1;
    tl_d    = tl_q << 1;
    tv_d[0] = fire;
    tf_d[0] = fire & is_first;
    tl_d[0] = fire & cand_last;
    acc_d   = acc_q;
    if (e_v) acc_d = e_f ? madd_result : acc_sum;
    pend_d  = pend_q + CW'(fire & cand_last) - CW'(push);
    count_d = count_q + CW'(push) - CW'(pop);
    wr_d    = wr_q + PW'(push);
    rd_d    = rd_q + PW'(pop);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      tv_q    <= '0;
      tf_q    <= '0;
      tl_q    <= '0;
      pend_q  <= '0;
      count_q <= '0;
      wr_q    <= '0;
      rd_q    <= '0;
      acc_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      tv_q    <= tv_d;
      tf_q    <= tf_d;
      tl_q    <= tl_d;
      pend_q  <= pend_d;
      count_q <= count_d;
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      acc_q   <= acc_d;
    end
  end

  always_ff @(posedge clock) begin
    if (push) mem_q[wr_q] <= acc_d;
  end

`ifdef MADD_SEQ_OVF_DETECT_EN
  logic ovf_q, ovf_d;
  logic step_ovf;

  // Same-sign operands producing a different-sign sum is a signed overflow.
  assign step_ovf = (acc_q[31] == madd_result[31]) &
                    (acc_sum[31] != acc_q[31]);

  always_comb begin
    ovf_d = ovf_q;
    if (e_v) ovf_d = e_f ? 1'b0 : (ovf_q | step_ovf);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) ovf_q <= 1'b0;
    else       ovf_q <= ovf_d;
  end

  assign ovf_flag = ovf_q;
`else
  assign ovf_flag = 1'b0;
`endif

endmodule

// File: tb/tb_madd_dot_sequencer.sv
// Bench for madd_dot_sequencer: latency-L MADD model plus per-product sum scoreboard.
module tb_madd_dot_sequencer;
  localparam int L  = 4;
  localparam int LW = 16;
  localparam int D  = 8;
`ifdef MADD_SEQ_OVF_DETECT_EN
  localparam bit OVF_EN = 1'b1;
`else
  localparam bit OVF_EN = 1'b0;
`endif

  logic          clock = 0;
  logic          reset;
  logic [LW-1:0] cfg_len;
  logic          in_valid;
  logic          in_ready;
  logic [63:0]   in_a, in_b;
  logic [63:0]   madd_a, madd_b;
  logic [31:0]   madd_result;
  logic          out_valid;
  logic          out_ready;
  logic [31:0]   out_data;
  logic          busy;
  logic          ovf_flag;

  int n_chk = 0;
  int n_fail = 0;
  logic [31:0] exp_q [$];

  logic        ovr_en = 0;
  logic [31:0] ovr_val = 0;
  logic [31:0] pipe [L];

  always #5 clock = ~clock;

  madd_dot_sequencer #(
    .MADD_LATENCY(L), .LEN_WIDTH(LW), .OFIFO_DEPTH(D)
  ) dut (
    .clock(clock), .reset(reset), .cfg_len(cfg_len),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b),
    .madd_a(madd_a), .madd_b(madd_b),
    .madd_result(madd_result),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .busy(busy), .ovf_flag(ovf_flag)
  );

  function automatic logic [31:0] dot(input logic [63:0] a, input logic [63:0] b);
    int s;
    s = 0;
    for (int i = 0; i < 8; i++)
      s += int'($signed(a[8*i+:8])) * int'($signed(b[8*i+:8]));
    return s;
  endfunction

  // Behavioural MADD: result of the lanes it was fed appears L cycles later.
  always @(posedge clock) begin
    pipe[0] <= (in_valid && in_ready) ? (ovr_en ? ovr_val : dot(madd_a, madd_b)) : 32'h0;
    for (int i = 1; i < L; i++) pipe[i] <= pipe[i-1];
  end
  assign madd_result = pipe[L-1];

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic beat(input logic [63:0] a, input logic [63:0] b,
                      input logic [LW-1:0] cfg, input bit oe,
                      input logic [31:0] ov, output bit ok);
    bit f;
    in_valid = 1; in_a = a; in_b = b; cfg_len = cfg;
    ovr_en = oe; ovr_val = ov; ok = 0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clock); f = in_ready;
      @(posedge clock); #1;
      if (f) begin ok = 1; break; end
    end
    in_valid = 0; ovr_en = 0;
    n_chk++;
    if (!ok) begin
      n_fail++;
      $display("FAIL beat_accept: in_ready=0 for 300 cycles, required 1");
    end
  endtask

  task automatic send_prod(input int cfg, input bit oe, input logic [31:0] ov);
    int n;
    bit ok;
    logic [31:0] sum, v;
    logic [63:0] a, b;
    n = (cfg == 0) ? 1 : cfg;
    sum = 0;
    for (int j = 0; j < n; j++) begin
      a = {$urandom, $urandom};
      b = {$urandom, $urandom};
      v = oe ? ov : dot(a, b);
      sum = (j == 0) ? v : sum + v;
      beat(a, b, (j == 0) ? LW'(cfg) : LW'($urandom_range(0, 7)), oe, ov, ok);
    end
    exp_q.push_back(sum);
  endtask

  task automatic pop_out(input bit rnd, output logic [31:0] d,
                         output logic ov, output bit ok);
    ok = 0; d = 0; ov = 0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clock);
      if (out_valid && out_ready) begin
        d = out_data; ov = ovf_flag; ok = 1;
        @(posedge clock); #1;
        return;
      end
      @(posedge clock); #1;
      if (rnd) out_ready = 1'($urandom_range(0, 1));
    end
  endtask

  task automatic test_reset;
    reset = 1; in_valid = 1; cfg_len = 1;
    in_a = '1; in_b = '1; out_ready = 1;
    #3;
    n_chk++;
    if ({in_ready, out_valid, busy, ovf_flag} !== 4'b0) begin
      n_fail++;
      $display("FAIL reset_flags: rdy/ov/busy/ovf=%b required 0000",
               {in_ready, out_valid, busy, ovf_flag});
    end
    n_chk++;
    if (madd_a !== 64'h0 || madd_b !== 64'h0 || out_data !== 32'h0) begin
      n_fail++;
      $display("FAIL reset_data: madd_a=%h madd_b=%h out_data=%h required 0",
               madd_a, madd_b, out_data);
    end
    @(posedge clock); @(posedge clock); #1;
    in_valid = 0; reset = 0;
    @(posedge clock); #1;
  endtask

  task automatic test_single;
    bit f;
    int early;
    in_valid = 1; cfg_len = 1;
    in_a = {8{8'd2}}; in_b = {8{8'd3}};
    @(negedge clock); f = in_ready;
    n_chk++;
    if (!f || madd_a !== in_a || madd_b !== in_b) begin
      n_fail++;
      $display("FAIL single_fire: rdy=%b madd_a=%h madd_b=%h required 1/%h/%h",
               f, madd_a, madd_b, in_a, in_b);
    end
    @(posedge clock); #1;
    in_valid = 0;
    early = 0;
    for (int k = 0; k < L; k++) begin
      @(negedge clock);
      if (k == 0) begin
        n_chk++;
        if (madd_a !== 64'h0 || busy !== 1'b1) begin
          n_fail++;
          $display("FAIL single_idle: madd_a=%h busy=%b required 0/1", madd_a, busy);
        end
      end
      if (out_valid) early++;
    end
    n_chk++;
    if (early != 0) begin
      n_fail++;
      $display("FAIL single_early: out_valid seen %0d early cycles, required 0", early);
    end
    @(negedge clock);
    n_chk++;
    if (out_valid !== 1'b1 || out_data !== 32'd48) begin
      n_fail++;
      $display("FAIL single_result: valid=%b data=%0d required 1/48", out_valid, out_data);
    end
    @(posedge clock); #1;
  endtask

  task automatic test_multi;
    logic [31:0] d; logic ov; bit ok;
    int extra;
    out_ready = 1;
    fork
      begin
        for (int j = 0; j < 4; j++)
          beat({$urandom, $urandom}, {$urandom, $urandom},
               (j == 0) ? LW'(4) : LW'(9), 1'b1, 32'd10, ok);
        for (int k = 0; k < L; k++) begin
          @(negedge clock);
          n_chk++;
          if (busy !== 1'b1) begin
            n_fail++;
            $display("FAIL multi_busy_hold: cycle %0d busy=%b required 1", k, busy);
          end
        end
        @(negedge clock);
        n_chk++;
        if (busy !== 1'b0) begin
          n_fail++;
          $display("FAIL multi_busy_drop: busy=%b required 0", busy);
        end
      end
      begin
        pop_out(1'b0, d, ov, ok);
        n_chk++;
        if (!ok || d !== 32'd40) begin
          n_fail++;
          $display("FAIL multi_result: ok=%b data=%0d required 1/40", ok, d);
        end
      end
    join
    extra = 0;
    repeat (L + 3) begin
      @(negedge clock);
      if (out_valid) extra++;
    end
    n_chk++;
    if (extra != 0) begin
      n_fail++;
      $display("FAIL multi_count: %0d extra valid cycles, required 0", extra);
    end
    @(posedge clock); #1;
  endtask

  task automatic run_products(input string name, input int n, input bit rnd,
                              input int cmin, input int cmax);
    logic [31:0] d, e; logic ov; bit ok;
    fork
      for (int p = 0; p < n; p++)
        send_prod($urandom_range(cmin, cmax), 1'b0, 32'h0);
      for (int p = 0; p < n; p++) begin
        pop_out(rnd, d, ov, ok);
        e = (exp_q.size() != 0) ? exp_q.pop_front() : 32'hDEAD_BEEF;
        n_chk++;
        if (!ok || d !== e) begin
          n_fail++;
          $display("FAIL %s[%0d]: ok=%b data=%h required %h", name, p, ok, d, e);
        end
      end
    join
    out_ready = 1;
  endtask

  task automatic test_len0;
    out_ready = 1;
    run_products("len0", 3, 1'b0, 0, 0);
  endtask

  task automatic test_back_to_back;
    out_ready = 1;
    run_products("b2b", 10, 1'b0, 1, 3);
    run_products("random", 20, 1'b1, 0, 5);
  endtask

  task automatic test_backpressure;
    logic [31:0] d, e; logic ov; bit ok;
    out_ready = 0;
    for (int p = 0; p < 8; p++) send_prod(1, 1'b0, 32'h0);
    cfg_len = 2; #1;
    n_chk++;
    if (in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL bp_nonlast: in_ready=%b required 1", in_ready);
    end
    cfg_len = 1; #1;
    n_chk++;
    if (in_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL bp_last: in_ready=%b required 0", in_ready);
    end
    repeat (L + 3) @(posedge clock);
    #1;
    n_chk++;
    if (in_ready !== 1'b0 || out_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL bp_hold: in_ready=%b out_valid=%b required 0/1", in_ready, out_valid);
    end
    out_ready = 1;
    fork
      for (int p = 0; p < 4; p++) send_prod(1, 1'b0, 32'h0);
      for (int p = 0; p < 12; p++) begin
        pop_out(1'b0, d, ov, ok);
        e = (exp_q.size() != 0) ? exp_q.pop_front() : 32'hDEAD_BEEF;
        n_chk++;
        if (!ok || d !== e) begin
          n_fail++;
          $display("FAIL bp_drain[%0d]: ok=%b data=%h required %h", p, ok, d, e);
        end
      end
    join
  endtask

  task automatic test_reset_midflight;
    logic [31:0] d, e; logic ov; bit ok;
    int seen;
    out_ready = 1;
    beat({$urandom, $urandom}, {$urandom, $urandom}, LW'(3), 1'b0, 32'h0, ok);
    beat({$urandom, $urandom}, {$urandom, $urandom}, LW'(3), 1'b0, 32'h0, ok);
    @(posedge clock); #1;
    @(posedge clock); #2;
    in_valid = 1; cfg_len = 1;
    reset = 1;
    #1;
    n_chk++;
    if ({in_ready, out_valid, busy} !== 3'b0 || madd_a !== 64'h0 || out_data !== 32'h0) begin
      n_fail++;
      $display("FAIL rst_async: rdy/ov/busy=%b madd_a=%h data=%h required 000/0/0",
               {in_ready, out_valid, busy}, madd_a, out_data);
    end
    @(posedge clock); @(posedge clock); #1;
    in_valid = 0; reset = 0;
    seen = 0;
    repeat (L + 4) begin
      @(negedge clock);
      if (out_valid || busy) seen++;
    end
    n_chk++;
    if (seen != 0) begin
      n_fail++;
      $display("FAIL rst_discard: %0d cycles with output/busy, required 0", seen);
    end
    @(posedge clock); #1;
    send_prod(1, 1'b0, 32'h0);
    pop_out(1'b0, d, ov, ok);
    e = (exp_q.size() != 0) ? exp_q.pop_front() : 32'hDEAD_BEEF;
    n_chk++;
    if (!ok || d !== e) begin
      n_fail++;
      $display("FAIL rst_after: ok=%b data=%h required %h", ok, d, e);
    end
  endtask

  task automatic test_ovf;
    logic [31:0] d; logic ov; bit ok;
    out_ready = 1;
    beat({$urandom, $urandom}, {$urandom, $urandom}, LW'(2), 1'b1, 32'h7FFF_FFFF, ok);
    beat({$urandom, $urandom}, {$urandom, $urandom}, LW'(2), 1'b1, 32'h1, ok);
    pop_out(1'b0, d, ov, ok);
    n_chk++;
    if (!ok || d !== 32'h8000_0000 || ov !== OVF_EN) begin
      n_fail++;
      $display("FAIL ovf_set: ok=%b data=%h ovf=%b required 1/80000000/%b", ok, d, ov, OVF_EN);
    end
    beat({$urandom, $urandom}, {$urandom, $urandom}, LW'(1), 1'b1, 32'd5, ok);
    pop_out(1'b0, d, ov, ok);
    n_chk++;
    if (!ok || d !== 32'd5 || ov !== 1'b0) begin
      n_fail++;
      $display("FAIL ovf_clear: ok=%b data=%h ovf=%b required 1/5/0", ok, d, ov);
    end
  endtask

  initial begin
    cfg_len = 0; in_valid = 0; in_a = 0; in_b = 0; out_ready = 0; reset = 1;
    test_reset;
    test_single;
    test_multi;
    test_len0;
    test_back_to_back;
    test_backpressure;
    test_reset_midflight;
    test_ovf;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
